// File: rtl/sseg_pkg.sv
// Shared constants and the hex-to-segment decode for the seven-segment scanner.
package sseg_pkg;

  localparam logic [7:0]  SEG_OFF    = 8'hFF;
  localparam int unsigned NUM_PHASES = 16;
  localparam int unsigned PHASE_W    = $clog2(NUM_PHASES);

  // Active-low {a,b,c,d,e,f,g} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] i_hex);
    logic [6:0] w_seg;
    case (i_hex)
      4'h0: w_seg = 7'b0000001;
      4'h1: w_seg = 7'b1001111;
      4'h2: w_seg = 7'b0010010;
      4'h3: w_seg = 7'b0000110;
      4'h4: w_seg = 7'b1001100;
      4'h5: w_seg = 7'b0100100;
      4'h6: w_seg = 7'b0100000;
      4'h7: w_seg = 7'b0001111;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0000100;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b1100000;
      4'hC: w_seg = 7'b0110001;
      4'hD: w_seg = 7'b1000010;
      4'hE: w_seg = 7'b0110000;
      default: w_seg = 7'b0111000;
    endcase
    return w_seg;
  endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// Scan timing: slot prescaler, brightness phase within the slot, digit index
// and the registered slot_tick pulse.
module sseg_scan_timer
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned SLOT_CYCLES = 50000,
  localparam int unsigned IW = $clog2(NUM_DIGITS)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IW-1:0]      idx,
  output logic [PHASE_W-1:0] phase,
  output logic               slot_start_c,
  output logic               slot_tick
);

  localparam int unsigned PH_LEN = SLOT_CYCLES / NUM_PHASES;
  localparam int unsigned PW     = $clog2(SLOT_CYCLES);
  localparam int unsigned SW     = $clog2(PH_LEN);

  logic [PW-1:0]      r_presc;
  logic [SW-1:0]      r_sub;
  logic [PHASE_W-1:0] r_phase;
  logic [IW-1:0]      r_idx;
  logic               r_tick;

  assign slot_start_c = (r_presc == '0);
  assign idx          = r_idx;
  assign phase        = r_phase;
  assign slot_tick    = r_tick;

  // Prescaler with phase sub-counter; the prescaler wrap advances the digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_sub   <= '0;
      r_phase <= '0;
      r_idx   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= slot_start_c;
      if (r_presc == PW'(SLOT_CYCLES - 1)) begin
        r_presc <= '0;
        r_sub   <= '0;
        r_phase <= '0;
        r_idx   <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
        if (r_sub == SW'(PH_LEN - 1)) begin
          r_sub   <= '0;
          r_phase <= r_phase + PHASE_W'(1);
        end else begin
          r_sub <= r_sub + SW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sseg_scan_mux.sv
// Multiplexed seven-segment display driver with per-digit brightness PWM,
// raw-pattern override and optional leading-zero blanking (SSEG_LZB_EN).
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned SLOT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    active,
  input  logic [3:0]              bright,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   raw_en,
  input  logic [8*NUM_DIGITS-1:0] raw_seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic                    slot_tick
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] DIG0 = NUM_DIGITS'(1);

  logic [IW-1:0]      w_idx;
  logic [PHASE_W-1:0] w_phase;
  logic               w_slot_start;
  logic               w_tick;
  logic [3:0]         w_hex;
  logic [7:0]         w_live_seg;
  logic [7:0]         w_cur_seg;
  logic [3:0]         w_cur_bright;
  logic               w_lz_blank;
  logic               w_on;

  logic [NUM_DIGITS-1:0] r_an;
  logic [7:0]            r_sseg;
  logic [7:0]            r_snap_seg;
  logic [3:0]            r_snap_bright;

  sseg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .idx          (w_idx),
    .phase        (w_phase),
    .slot_start_c (w_slot_start),
    .slot_tick    (w_tick)
  );

`ifdef SSEG_LZB_EN
  // Blank digit i>0 when it and every higher digit are plain zeros.
  always_comb begin
    w_lz_blank = (w_idx != '0);
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (j >= 32'(w_idx)) begin
        if ((hex_in[4*j +: 4] != 4'h0) || raw_en[j]) begin
          w_lz_blank = 1'b0;
        end
      end
    end
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  // Pattern for the selected digit from live inputs (used at slot start).
  always_comb begin
    w_hex      = hex_in[4*32'(w_idx) +: 4];
    w_live_seg = {dp_in[w_idx], hex_to_seg(w_hex)};
    if (raw_en[w_idx]) begin
      w_live_seg = raw_seg[8*32'(w_idx) +: 8];
    end else if (w_lz_blank) begin
      w_live_seg = SEG_OFF;
    end
  end

  // On the first slot cycle the snapshot is still being loaded, so bypass it.
  always_comb begin
    w_cur_seg    = w_slot_start ? w_live_seg : r_snap_seg;
    w_cur_bright = w_slot_start ? bright     : r_snap_bright;
    w_on         = active && (w_phase <= w_cur_bright);
  end

  // Slot snapshot and registered anode/segment outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an          <= '1;
      r_sseg        <= SEG_OFF;
      r_snap_seg    <= SEG_OFF;
      r_snap_bright <= '0;
    end else begin
      if (w_slot_start) begin
        r_snap_seg    <= w_live_seg;
        r_snap_bright <= bright;
      end
      if (w_on) begin
        r_an   <= ~(DIG0 << w_idx);
        r_sseg <= w_cur_seg;
      end else begin
        r_an   <= '1;
        r_sseg <= SEG_OFF;
      end
    end
  end

  assign an        = r_an;
  assign sseg      = r_sseg;
  assign slot_tick = w_tick;

endmodule

// File: doc/sseg_scan_mux.md
SSEG_SCAN_MUX -- requirements
Module: sseg_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, meaning number of multiplexed digits, legal range 2..16.
REQ-002 SHALL have parameter SLOT_CYCLES, default 50000, meaning clk cycles per digit slot; it must be a multiple of 16 and at least 32.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  system clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 active  in  1  display enable; 0 blanks the whole display.
REQ-006 bright  in  4  brightness level 0..15; 15 means full on-time.
REQ-007 hex_in  in  4*NUM_DIGITS  hex value per digit; digit i is bits [4i+3:4i].
REQ-008 dp_in  in  NUM_DIGITS  decimal point per digit, active-low, passed through to sseg[7].
REQ-009 raw_en  in  NUM_DIGITS  per-digit raw mode; 1 selects the raw_seg pattern instead of the hex decode.
REQ-010 raw_seg  in  8*NUM_DIGITS  raw active-low pattern {dp,a,b,c,d,e,f,g} per digit.
REQ-011 an  out  NUM_DIGITS  active-low anode enables, registered.
REQ-012 sseg  out  8  active-low {dp,a..g}, with segment a at bit 6 and g at bit 0, registered.
REQ-013 slot_tick  out  1  one-cycle pulse on the first cycle of every digit slot.

Function
REQ-014 SHALL run a prescaler counting 0..SLOT_CYCLES-1 and wrapping; the wrap to 0 starts a new slot and advances the digit index.
REQ-015 Digit index SHALL count 0..NUM_DIGITS-1 and wrap to 0, including for non-power-of-2 NUM_DIGITS.
REQ-016 At each slot start SHALL snapshot hex, dp, raw_en, raw_seg and bright for the selected digit; changes mid-slot SHALL take effect at the next slot.
REQ-017 Slot SHALL be split into 16 equal phases of SLOT_CYCLES/16 cycles; the anode is asserted only while phase <= snapped bright.
REQ-018 While the anode is deasserted within a slot, sseg SHALL be 8'hFF.
REQ-019 Hex decode SHALL use this table (g..a order omitted; values given as sseg[6:0]):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100
  - 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, B=1100000
  - C=0110001, D=1000010, E=0110000, F=0111000
REQ-020 Raw mode SHALL output raw_seg for the digit verbatim, dp included, ignoring dp_in.
REQ-021 an and sseg SHALL be registered, lagging the prescaler/index by exactly 1 clk; slot_tick SHALL align with the first registered output of the slot.
REQ-022 active=0 SHALL force an all-ones and sseg=8'hFF from the next clk; the scan counters keep running.

Reset
REQ-023 On reset assertion, the module SHALL immediately set: prescaler=0, index=0, an all-ones, sseg=8'hFF, slot_tick=0, snapshots cleared.
REQ-024 First slot after release SHALL be digit 0; reset mid-slot SHALL abandon the slot without completing it.

Configuration
REQ-025 Macro SSEG_LZB_EN, when defined, SHALL enable leading-zero blanking: a non-raw digit i>0 shows 8'hFF (dp included) when hex digits i..NUM_DIGITS-1 are all 0 and none of them is in raw mode; digit 0 is never blanked.
REQ-026 Without SSEG_LZB_EN, all digits SHALL display their decoded value, including leading zeros.

Structure
REQ-027 Package sseg_pkg SHALL hold the hex-to-segment function, SEG_OFF=8'hFF and the phase count constant 16.
REQ-028 Sub-module sseg_scan_timer SHALL contain the prescaler, phase, digit index and slot_tick generation.

Verification (NUM_DIGITS=3, SLOT_CYCLES=32 unless stated)
REQ-029 Test: reset release, bright=15, hex_in=12'h321 -> an cycles 110,101,011 in 32-clk slots with sseg[6:0] 1001111, 0010010, 0000110, then wraps to 110.
REQ-030 Test: bright=3 -> anode low for 8 of 32 clks per slot (phases 0..3), sseg=FF for the remaining 24.
REQ-031 Test: raw_en=3'b010, raw_seg digit1=8'h7E -> sseg=8'h7E during the digit1 slot, with dp_in ignored.
REQ-032 Test: hex_in=12'h005, with SSEG_LZB_EN -> digits 2 and 1 blank (FF) and digit 0 shows 0100100; without the macro -> digits 2 and 1 show 0000001.
REQ-033 Test: hex_in changed mid-slot and active=0 pulse -> new value appears only from the next slot; active=0 gives an=111 and sseg=FF one clk later.
REQ-034 Test: reset asserted at prescaler=17 on digit 2 -> outputs go off immediately, and after release the first slot_tick is for digit 0.
